seq_detect_sched: RTL

- Round-robin scheduler that shares one serial sequence detector among N_REQ requesters.
- Each requester submits a W-bit word. The block clears the detector, streams the word into it MSB-first (one bit per clock), counts detector match pulses, and returns the count tagged with the requester id.
- Sits between requester logic and a single instance of the team's serial detector (det_in / det_out / det_reset wiring).

---
 rtl/seq_detect_sched.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/seq_detect_sched.sv
// seq_detect_sched
// Shares one serial sequence detector among N_REQ requesters, served in
// round-robin order. For each accepted word the block clears the detector,
// streams the word into it MSB-first, counts det_out pulses over a W-cycle
// window aligned to the detector latency, then returns the count tagged with
// the requester id.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   req_valid  per-requester pending flag
//   req_data   word of requester i at [i*W +: W]
//   req_ready  one-hot grant (combinational, only while idle)
//   det_reset  registered clear to the detector
//   det_in     registered serial bit to the detector
//   det_out    detector match flag
//   rsp_valid  response available
//   rsp_id     index of the served requester
//   rsp_count  saturating count of det_out=1 cycles in the window
//   rsp_ready  response consumer ready
//   busy       high whenever a frame is in flight or awaiting handshake
module seq_detect_sched #(
    parameter int N_REQ   = 4,
    parameter int W       = 8,
    parameter int CNT_W   = 4,
    parameter int DET_LAT = 1,
    localparam int ID_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [N_REQ*W-1:0]   req_data,
    output logic [N_REQ-1:0]     req_ready,
    output logic                 det_reset,
    output logic                 det_in,
    input  logic                 det_out,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [CNT_W-1:0]     rsp_count,
    input  logic                 rsp_ready,
    output logic                 busy
);

    // step counts cycles from the first SHIFT cycle through the last DRAIN cycle
    localparam int STEP_W = $clog2(W + DET_LAT + 1);
    localparam logic [STEP_W-1:0] SHIFT_LAST = STEP_W'(W - 1);
    localparam logic [STEP_W-1:0] LAST_STEP  = STEP_W'(W + DET_LAT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        RESP
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [W-1:0]       shift_reg;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [STEP_W-1:0]  step;
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            int j;
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            if (!grant_found && req_valid[j]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(j);
            end
        end
    end

    // Grant is visible only while idle and never while reset is held, so a
    // requester cannot believe it was accepted by a frame that gets discarded.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state == IDLE) && !reset && grant_found
                                   && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // det_out is counted only once the first streamed bit can have produced a
    // response; earlier pulses (e.g. during CLEAR) belong to no bit of ours.
    always_comb begin
        cnt_next = cnt;
        if ((int'(step) >= DET_LAT) && det_out && (cnt != CNT_MAX)) begin
            cnt_next = cnt + 1'b1;
        end
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            shift_reg <= '0;
            cnt       <= '0;
            step      <= '0;
            det_reset <= 1'b1;
            det_in    <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    det_reset <= 1'b0;
                    det_in    <= 1'b0;
                    if (grant_found) begin
                        shift_reg <= req_data[grant_idx*W +: W];
                        rsp_id    <= grant_idx;
                        rr_ptr    <= (int'(grant_idx) == N_REQ - 1) ? '0 : grant_idx + 1'b1;
                        cnt       <= '0;
                        det_reset <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    det_reset <= 1'b0;
                    det_in    <= shift_reg[W-1];
                    shift_reg <= {shift_reg[W-2:0], 1'b0};
                    step      <= '0;
                    state     <= SHIFT;
                end
                SHIFT, DRAIN: begin
                    cnt  <= cnt_next;
                    step <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        det_in    <= 1'b0;
                        rsp_count <= cnt_next;
                        rsp_valid <= 1'b1;
                        state     <= RESP;
                    end else if ((state == SHIFT) && (step != SHIFT_LAST)) begin
                        det_in    <= shift_reg[W-1];
                        shift_reg <= {shift_reg[W-2:0], 1'b0};
                    end else begin
                        det_in <= 1'b0;
                        state  <= DRAIN;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
